// File: rtl/alu_arbiter_pkg.sv
// Shared opcode map, FSM state encoding and opcode helpers for the ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [7:0] OP_ADD    = 8'h00;
  localparam logic [7:0] OP_SUB    = 8'h01;
  localparam logic [7:0] OP_MUL    = 8'h02;
  localparam logic [7:0] OP_DIV    = 8'h03;
  localparam logic [7:0] OP_CMP_EQ = 8'h04;
  localparam logic [7:0] OP_CMP_LT = 8'h05;
  localparam logic [7:0] OP_CMP_GT = 8'h06;
  localparam logic [7:0] OP_NOT    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h09;
  localparam logic [7:0] OP_OR     = 8'h0A;
  localparam logic [7:0] OP_XOR    = 8'h0B;
  localparam logic [7:0] OP_SHL    = 8'h10;
  localparam logic [7:0] OP_SHR    = 8'h11;
  localparam logic [7:0] OP_MOD    = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Divide and modulo need the ALU inputs held for a longer window.
  function automatic logic is_multicycle(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the ALU arbiter, grouped as one bus.
interface alu_arbiter_if #(
  parameter int N   = 2,
  parameter int W   = 8,
  parameter int IDW = 1
);
  logic [N-1:0]   req;
  logic [N*8-1:0] req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;

  logic [7:0]     alu_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic [7:0]     alu_flags;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic [7:0]     rsp_flags;

  modport slave (
    input  req, req_op, req_a, req_b, alu_result, alu_flags, rsp_ready,
    output gnt, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport master (
    output req, req_op, req_a, req_b, alu_result, alu_flags, rsp_ready,
    input  gnt, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational; gnt is one-hot (or zero) and idx is its index.
module rr_picker #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  assign any = |req;

  always_comb begin
    int c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N requesters: round-robin accept,
// hold operands for a per-opcode window, return result over valid/ready.
//
// state | meaning
// IDLE  | waiting for a request; gnt driven combinationally from the picker
// EXEC  | ALU inputs held, counter running down to the capture edge
// RESP  | result/flags held on rsp_*, waiting for rsp_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N          = 2,
  parameter int W          = 8,
  parameter int DIV_CYCLES = 4,
  parameter int IDW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic            busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_gnt;
  logic           pick_any;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           capture;
  logic           handshake;

  logic [7:0]     win_op;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;

  logic [7:0]     alu_op_q;
  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_result_q;
  logic [7:0]     rsp_flags_q;

  rr_picker #(.N(N), .IDW(IDW)) u_picker (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign win_op = bus.req_op[int'(pick_idx)*8 +: 8];
  assign win_a  = bus.req_a[int'(pick_idx)*W +: W];
  assign win_b  = bus.req_b[int'(pick_idx)*W +: W];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == CW'(1)) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          handshake = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant is masked while reset is asserted so gnt reads 0 even with req high.
  assign bus.gnt = (accept && rst_n) ? pick_gnt : '0;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      cnt          <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      if (accept) begin
        alu_op_q <= win_op;
        alu_a_q  <= win_a;
        alu_b_q  <= win_b;
        rsp_id_q <= pick_idx;
        ptr      <= (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
        cnt      <= is_multicycle(win_op) ? CW'(DIV_CYCLES) : CW'(1);
      end
      if (state == ST_EXEC) cnt <= cnt - CW'(1);
      if (capture) begin
        rsp_result_q <= bus.alu_result;
        rsp_flags_q  <= bus.alu_flags;
        rsp_valid_q  <= 1'b1;
      end else if (handshake) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a transaction-level model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  alu_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus ();

  alu_arbiter #(.N(N), .W(W), .DIV_CYCLES(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU, also used as the ALU the arbiter drives.
  function automatic logic [7:0] ref_alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_MUL:    return a * b;
      OP_DIV:    return (b == 8'h00) ? 8'hFF : a / b;
      OP_MOD:    return (b == 8'h00) ? a : a % b;
      OP_CMP_EQ: return {7'd0, a == b};
      OP_CMP_LT: return {7'd0, a < b};
      OP_CMP_GT: return {7'd0, a > b};
      OP_NOT:    return ~a;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SHL:    return a << b[2:0];
      OP_SHR:    return a >> b[2:0];
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ref_flags(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = ref_alu(op, a, b);
    return {r == 8'h00, r[7], a[2:0], b[2:0]};
  endfunction

  always_comb begin
    bus.alu_result = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_flags  = ref_flags(bus.alu_op, bus.alu_a, bus.alu_b);
  end

  // ---------------- transaction-level model ----------------
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  int             m_ptr, m_w, m_due, cyc;
  bit             m_idle, m_rsp;
  logic [7:0]     m_op, m_a, m_b, m_res, m_flg, m_pres, m_pflg;
  logic [7:0]     w_op, w_a, w_b;
  logic [IDW-1:0] m_id;

  always_comb m_w = model_pick(bus.req, m_ptr);

  always_comb begin
    w_op = 8'h00;
    w_a  = 8'h00;
    w_b  = 8'h00;
    if (m_w >= 0) begin
      w_op = bus.req_op[m_w*8 +: 8];
      w_a  = bus.req_a[m_w*W +: W];
      w_b  = bus.req_b[m_w*W +: W];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_idle <= 1'b1; m_rsp <= 1'b0; m_due <= 0; cyc <= 0;
      m_op <= '0; m_a <= '0; m_b <= '0; m_id <= '0;
      m_res <= '0; m_flg <= '0; m_pres <= '0; m_pflg <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_idle) begin
        if (m_w >= 0) begin
          m_op   <= w_op;
          m_a    <= w_a;
          m_b    <= w_b;
          m_id   <= IDW'(m_w);
          m_ptr  <= (m_w + 1) % N;
          m_due  <= cyc + (((w_op == 8'h03) || (w_op == 8'h13)) ? DIV : 1);
          m_pres <= ref_alu(w_op, w_a, w_b);
          m_pflg <= ref_flags(w_op, w_a, w_b);
          m_idle <= 1'b0;
        end
      end else if (!m_rsp) begin
        if (cyc == m_due) begin
          m_rsp <= 1'b1;
          m_res <= m_pres;
          m_flg <= m_pflg;
        end
      end else if (bus.rsp_ready) begin
        m_rsp  <= 1'b0;
        m_idle <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt",        32'(bus.gnt), (m_idle && m_w >= 0) ? (32'd1 << m_w) : 32'd0);
      chk("busy",       32'(busy),           32'(!m_idle));
      chk("rsp_valid",  32'(bus.rsp_valid),  32'(m_rsp));
      chk("rsp_id",     32'(bus.rsp_id),     32'(m_id));
      chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
      chk("rsp_flags",  32'(bus.rsp_flags),  32'(m_flg));
      chk("alu_inputs", {8'd0, bus.alu_op, bus.alu_a, bus.alu_b}, {8'd0, m_op, m_a, m_b});
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] ops [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h13, 8'h04, 8'h05, 8'h06,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h10, 8'h11, 8'h7F, 8'hFF};
  int g_ord [4];
  int r_ids [4];
  int ng, nr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[i*8 +: 8] = op;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
    bus.req[i]           = 1'b1;
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    bus.rsp_ready = 1'b1;
    while (busy && t < 50) begin tick(); t++; end
    chk("drain_idle", 32'(busy), 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  // Drives one op from requester i; returns cycles from accept edge to rsp_valid.
  task automatic run_op(input int i, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int lat);
    tick();
    set_req(i, op, a, b);
    #1 chk("gnt_same_cycle", 32'(bus.gnt), 32'd1 << i);
    tick();
    bus.req[i] = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("idle_after_handshake", {31'd0, busy}, 32'd0);
    chk("valid_after_handshake", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Records grant order and response ids until n responses are seen.
  task automatic collect(input logic [N-1:0] mask, input bit hold, input int n);
    logic [N-1:0] g;
    int t;
    ng = 0; nr = 0; t = 0;
    bus.rsp_ready = 1'b1;
    while (nr < n && t < 100) begin
      #1;
      g = bus.gnt;
      if (g != '0) begin
        chk("gnt_onehot", 32'($onehot(g)), 32'd1);
        if (ng < 4) g_ord[ng] = idx_of(g);
        ng++;
      end
      if (bus.rsp_valid) begin
        if (nr < 4) r_ids[nr] = int'(bus.rsp_id);
        nr++;
      end
      tick();
      t++;
      if (!hold) bus.req = bus.req & ~g;
    end
    bus.req = bus.req & ~mask;
    chk("collect_count", 32'(nr), 32'(n));
    wait_idle();
  endtask

  initial begin
    int lat;
    logic [N-1:0] g;
    bus.req = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    #12;
    chk("rst_gnt_busy_valid", {29'd0, bus.gnt == '0, busy, bus.rsp_valid}, 32'h4);
    chk("rst_alu", {8'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 32'd0);
    chk("rst_rsp", {14'd0, bus.rsp_id, bus.rsp_result, bus.rsp_flags}, 32'd0);
    #10 rst_n = 1'b1;

    run_op(0, OP_ADD, 8'd5, 8'd3, lat);
    chk("add_latency", 32'(lat), 32'd1);
    chk("add_result", 32'(bus.rsp_result), 32'd8);
    chk("add_id", 32'(bus.rsp_id), 32'd0);
    finish_rsp();

    run_op(1, OP_DIV, 8'd100, 8'd7, lat);
    chk("div_latency", 32'(lat), 32'd4);
    chk("div_result", 32'(bus.rsp_result), 32'd14);
    chk("div_id", 32'(bus.rsp_id), 32'd1);
    finish_rsp();

    run_op(1, OP_MOD, 8'd100, 8'd7, lat);
    chk("mod_latency", 32'(lat), 32'd4);
    chk("mod_result", 32'(bus.rsp_result), 32'd2);
    finish_rsp();

    run_op(2, 8'h7F, 8'd9, 8'd9, lat);
    chk("undef_op_result", 32'(bus.rsp_result), 32'd0);
    finish_rsp();

    // Fairness: req0/req1 held continuously; pointer sits at 0 here.
    tick();
    set_req(0, OP_SUB, 8'd9, 8'd4);
    set_req(1, OP_SUB, 8'd50, 8'd8);
    collect(3'b011, 1'b1, 4);
    chk("fair_order", {g_ord[0][7:0], g_ord[1][7:0], g_ord[2][7:0], g_ord[3][7:0]}, 32'h00010001);
    chk("fair_ids", {r_ids[0][7:0], r_ids[1][7:0], r_ids[2][7:0], r_ids[3][7:0]}, 32'h00010001);

    // Backpressure: pointer at 2; requester 0 waits while the response is held.
    tick();
    set_req(2, OP_ADD, 8'd10, 8'd20);
    #1 chk("bp_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.req[2] = 1'b0;
    set_req(0, OP_XOR, 8'h0F, 8'hF0);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", {23'd0, bus.gnt, busy, bus.rsp_valid, 2'd0, bus.rsp_id},
                     {23'd0, 3'b000, 1'b1, 1'b1, 2'd0, 2'd2});
      chk("bp_data", {8'd0, bus.rsp_result, bus.alu_op, bus.alu_a}, {8'd0, 8'd30, OP_ADD, 8'd10});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_idle_after_ready", 32'(busy), 32'd0);
    chk("bp_pending_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req[0] = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
    chk("xor_result", 32'(bus.rsp_result), 32'hFF);
    finish_rsp();

    // Reset in the middle of a divide (pointer at 1).
    tick();
    set_req(1, OP_DIV, 8'd200, 8'd9);
    #1 chk("rst_div_gnt", 32'(bus.gnt), 32'h2);
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_busy", {30'd0, bus.rsp_valid, busy}, 32'd0);
    chk("midrst_alu_op", 32'(bus.alu_op), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    set_req(0, OP_ADD, 8'd1, 8'd2);
    set_req(1, OP_ADD, 8'd3, 8'd4);
    #1 chk("post_reset_gnt", 32'(bus.gnt), 32'h1);
    collect(3'b011, 1'b0, 2);
    chk("post_reset_ids", {16'd0, r_ids[0][7:0], r_ids[1][7:0]}, 32'h0001);

    // Pointer wrap: pointer at 2 with requesters 2 and 0 pending.
    tick();
    set_req(0, OP_SHL, 8'h03, 8'd2);
    set_req(2, OP_NOT, 8'h0F, 8'd0);
    collect(3'b101, 1'b0, 2);
    chk("wrap_order", {16'd0, g_ord[0][7:0], g_ord[1][7:0]}, 32'h0200);
    chk("wrap_ids", {16'd0, r_ids[0][7:0], r_ids[1][7:0]}, 32'h0200);

    // Random traffic; requesters hold until granted, then drop or reissue.
    tick();
    for (int c = 0; c < 3000; c++) begin
      #1;
      g = bus.gnt;
      tick();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (g[i] || !bus.req[i]) begin
          if ((g[i] && $urandom_range(0, 1) == 1) || (!g[i] && $urandom_range(0, 3) == 0))
            set_req(i, ops[$urandom_range(0, 15)], 8'($urandom),
                    ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
          else if (g[i])
            bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
